// File: rtl/tk_lane_ctrl.sv
// Tweakey lane controller: loads a 128-bit tweakey in BUSWIDTH-sized beats, then
// applies round / correct / restore commands and keeps a snapshot for restore.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no tweakey held; waiting for load_start
// LOAD  | shifting in beats; in_ready high
// READY | complete tweakey held; commands and snapshots accepted
module tk_lane_ctrl #(
    parameter int BUSWIDTH = 128,
    parameter int RCNTW    = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_start,
    input  logic [BUSWIDTH-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          cmd,
    input  logic                cmd_valid,
    input  logic                snap,
    input  logic [127:0]        tk_next,
    input  logic [127:0]        tk_corr,
    output logic [127:0]        tk,
    output logic                loaded,
    output logic [RCNTW-1:0]    round_cnt,
    output logic                cmd_err
);

    localparam int NB  = 128 / BUSWIDTH;
    localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BCW-1:0] BC_LAST = BCW'(NB - 1);

    localparam logic [1:0] CMD_NOP     = 2'b00;
    localparam logic [1:0] CMD_ROUND   = 2'b01;
    localparam logic [1:0] CMD_CORRECT = 2'b10;
    localparam logic [1:0] CMD_RESTORE = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        READY = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [127:0]       tk_q, tk_d;
    logic [127:0]       snap_q, snap_d;
    logic [BCW-1:0]     beat_cnt_q, beat_cnt_d;
    logic [RCNTW-1:0]   round_cnt_q, round_cnt_d;
    logic               cmd_err_q, cmd_err_d;
    logic [127:0]       tk_shifted;
    logic               cmd_active;

    // Full-width beats replace the register outright; narrower beats shift in at the LSB end.
    generate
        if (BUSWIDTH == 128) begin : g_full_beat
            assign tk_shifted = in_data;
        end else begin : g_narrow_beat
            assign tk_shifted = {tk_q[127-BUSWIDTH:0], in_data};
        end
    endgenerate

    assign cmd_active = cmd_valid && (cmd != CMD_NOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tk_q        <= '0;
            snap_q      <= '0;
            beat_cnt_q  <= '0;
            round_cnt_q <= '0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tk_q        <= tk_d;
            snap_q      <= snap_d;
            beat_cnt_q  <= beat_cnt_d;
            round_cnt_q <= round_cnt_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tk_d        = tk_q;
        snap_d      = snap_q;
        beat_cnt_d  = beat_cnt_q;
        round_cnt_d = round_cnt_q;
        cmd_err_d   = cmd_err_q;

        // load_start overrides everything, including a beat presented in the same cycle.
        if (load_start) begin
            state_d     = LOAD;
            beat_cnt_d  = '0;
            round_cnt_d = '0;
            cmd_err_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_active) cmd_err_d = 1'b1;
                end
                LOAD: begin
                    if (cmd_active) cmd_err_d = 1'b1;
                    if (in_valid) begin
                        tk_d = tk_shifted;
                        if (beat_cnt_q == BC_LAST) begin
                            state_d    = READY;
                            snap_d     = tk_shifted;
                            beat_cnt_d = '0;
                        end else begin
                            beat_cnt_d = beat_cnt_q + 1'b1;
                        end
                    end
                end
                READY: begin
                    // Snapshot takes the pre-update value; restore uses the old snapshot.
                    if (snap) snap_d = tk_q;
                    if (cmd_valid) begin
                        unique case (cmd)
                            CMD_ROUND: begin
                                tk_d = tk_next;
                                if (round_cnt_q != {RCNTW{1'b1}})
                                    round_cnt_d = round_cnt_q + 1'b1;
                            end
                            CMD_CORRECT: begin
                                tk_d        = tk_corr;
                                round_cnt_d = '0;
                            end
                            CMD_RESTORE: begin
                                tk_d        = snap_q;
                                round_cnt_d = '0;
                            end
                            default: ;
                        endcase
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign tk        = tk_q;
    assign loaded    = (state_q == READY);
    assign in_ready  = (state_q == LOAD);
    assign round_cnt = round_cnt_q;
    assign cmd_err   = cmd_err_q;

endmodule

// File: doc/tk_lane_ctrl.md
TK_LANE_CTRL -- requirements
Module: tk_lane_ctrl

Interface
REQ-001 Parameter BUSWIDTH, default 128: load-beat width; SHALL be one of 8, 16, 32, 64, 128.
REQ-002 Parameter RCNTW, default 6: width of the round counter.
REQ-003 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1: reset; asynchronous assert, active-low.
REQ-005 Port load_start  input  1: single-cycle pulse; begins a new tweakey load.
REQ-006 Port in_data  input  BUSWIDTH: load beat.
REQ-007 Port in_valid  input  1: in_data is valid.
REQ-008 Port in_ready  output  1: block accepts a beat.
REQ-009 Port cmd  input  2: command code; 00 nop, 01 round, 10 correct, 11 restore.
REQ-010 Port cmd_valid  input  1: cmd is valid this cycle.
REQ-011 Port snap  input  1: capture the current tk into the snapshot register.
REQ-012 Port tk_next  input  128: external round-function tweakey output.
REQ-013 Port tk_corr  input  128: external correction (inverse schedule) output.
REQ-014 Port tk  output  128: current tweakey register.
REQ-015 Port loaded  output  1: a complete tweakey is held (state READY).
REQ-016 Port round_cnt  output  RCNTW: rounds applied since the last load, correct or restore.
REQ-017 Port cmd_err  output  1: sticky; a command was issued outside READY.

Function
REQ-018 The FSM SHALL have three states: IDLE, LOAD and READY.
REQ-019 load_start SHALL take priority over every other input in all states: FSM to LOAD, beat counter to 0, round_cnt to 0, cmd_err to 0; tk is unchanged.
REQ-020 In_ready SHALL be 1 only in LOAD.
REQ-021 A beat SHALL transfer only when in_valid=1 and in_ready=1 in the same cycle.
REQ-022 On each accepted beat, tk SHALL become {tk[127-BUSWIDTH:0], in_data}; with BUSWIDTH=128, tk SHALL become in_data.
REQ-023 The beat counter SHALL count to NB=128/BUSWIDTH.
REQ-024 On accepting beat NB, the FSM SHALL enter READY and the snapshot register SHALL capture the completed tk value.
REQ-025 loaded SHALL be asserted in the cycle after the final beat is accepted.
REQ-026 In LOAD, in_valid=0 SHALL stall the load with no state change.
REQ-027 In READY with cmd_valid=1, cmd=01 SHALL set tk to tk_next and set round_cnt to round_cnt+1, saturating at 2^RCNTW-1.
REQ-028 In READY with cmd_valid=1, cmd=10 SHALL set tk to tk_corr and clear round_cnt.
REQ-029 In READY with cmd_valid=1, cmd=11 SHALL set tk to the snapshot value and clear round_cnt.
REQ-030 In READY, cmd=00 SHALL cause no state change.
REQ-031 Each command SHALL complete in one cycle; commands SHALL be accepted back-to-back every cycle.
REQ-032 In READY, snap=1 SHALL capture the pre-update tk, even when a command executes in the same cycle.
REQ-033 snap outside READY SHALL be ignored.
REQ-034 cmd_valid=1 with cmd≠00 in IDLE or LOAD SHALL be ignored and SHALL set cmd_err.
REQ-035 cmd_err SHALL clear only on reset or load_start.
REQ-036 load_start in LOAD SHALL restart the load from beat 0 and discard the partial beats already shifted.
REQ-037 load_start and an accepted beat in the same cycle: the beat SHALL be discarded.
REQ-038 tk_next and tk_corr SHALL be sampled only in the cycle a command executes.

Reset
REQ-039 rst_n=0 SHALL immediately force: FSM to IDLE, tk=0, snapshot=0, beat counter=0, round_cnt=0, cmd_err=0, loaded=0, in_ready=0.
REQ-040 Reset asserted mid-load or mid-command SHALL abort the operation with no partial update surviving.
REQ-041 Operation SHALL resume on the first rising clk edge after rst_n deasserts.

Verification
REQ-042 BUSWIDTH=32: load_start, then beats 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F with a 2-cycle in_valid gap after beat 2 -> tk=0x000102030405060708090A0B0C0D0E0F, loaded=1 one cycle after beat 4, in_ready=0.
REQ-043 In READY, 5 consecutive round commands with tk_next=tk+1 -> tk incremented by 5, round_cnt=5; then restore -> tk equals the loaded value, round_cnt=0.
REQ-044 RCNTW=2, 5 round commands -> round_cnt saturates at 3; then correct with tk_corr=0xAA..AA -> tk=0xAA..AA, round_cnt=0.
REQ-045 snap and a round command in the same cycle, then restore -> tk equals the pre-round value.
REQ-046 cmd=01 during LOAD -> tk unchanged, cmd_err=1; load_start -> cmd_err=0.
REQ-047 rst_n pulsed low after beat 2 of 4 -> all outputs return to reset values asynchronously; a fresh 4-beat load then yields the correct tk.
